pipe_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 25 ++
 rtl/pipe_ctrl_mc_timer.sv | 62 ++++++
 rtl/pipe_ctrl.sv | 60 ++++++
 tb/tb_pipe_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: stall vector layout, the fixed stall
// masks, and the multi-cycle timer state encoding.
package cpu_defs;

  localparam int STALL_W     = 5;
  localparam int STALL_PC    = 0;
  localparam int STALL_IFID  = 1;
  localparam int STALL_IDEX  = 2;
  localparam int STALL_EXMEM = 3;
  localparam int STALL_MEMWB = 4;

  // Each mask holds every register up to the requesting stage; the register
  // just past the highest set bit loads a bubble.
  localparam logic [STALL_W-1:0] STALL_NONE = 5'b00000;
  localparam logic [STALL_W-1:0] STALL_IF   = 5'b00001;
  localparam logic [STALL_W-1:0] STALL_ID   = 5'b00011;
  localparam logic [STALL_W-1:0] STALL_EX   = 5'b00111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 5'b01111;

  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_e;

endpackage

// File: rtl/pipe_ctrl_mc_timer.sv
// Multi-cycle EX sequencer: IDLE/BUSY FSM with a down-counter that freezes
// under a MEM wait and is cleared by flush.
module mc_timer
  import cpu_defs::*;
#(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_mc_start,
  input  logic [CNT_W-1:0] ex_mc_cycles,
  input  logic             mem_stallreq,
  input  logic             flush_req,
  output logic             ex_mc_stall,
  output logic             ex_mc_done,
  output logic             ex_busy
);

  mc_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last;
  logic             mc_req;

  assign cnt_last = (cnt == CNT_W'(1));
  assign mc_req   = ex_mc_start && (ex_mc_cycles != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MC_IDLE;
      cnt   <= '0;
    end else if (flush_req) begin
      state <= MC_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        MC_IDLE: begin
          if (mc_req && !mem_stallreq) begin
            state <= MC_BUSY;
            cnt   <= ex_mc_cycles;
          end
        end
        MC_BUSY: begin
          // A MEM wait freezes the op in place; otherwise count down to done.
          if (!mem_stallreq) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt_last) state <= MC_IDLE;
          end
        end
        default: begin
          state <= MC_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // The first cycle the op is seen already stalls; the done cycle does not.
  assign ex_mc_stall = (state == MC_IDLE) ? mc_req : !cnt_last;
  assign ex_mc_done  = (state == MC_BUSY) && cnt_last && !mem_stallreq && !flush_req;
  assign ex_busy     = (state == MC_BUSY);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: priority-muxes stage stall requests into the per-stage
// hold vector and broadcasts flush; multi-cycle EX timing lives in mc_timer.
module pipe_ctrl
  import cpu_defs::*;
#(
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_stallreq,
  input  logic               id_stallreq,
  input  logic               ex_mc_start,
  input  logic [CNT_W-1:0]   ex_mc_cycles,
  input  logic               mem_stallreq,
  input  logic               flush_req,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic               ex_mc_done,
  output logic               ex_busy
);

  logic mc_stall;
  logic mc_done;
  logic mc_busy;

  mc_timer #(.CNT_W(CNT_W)) u_mc_timer (
    .clk          (clk),
    .rst          (rst),
    .ex_mc_start  (ex_mc_start),
    .ex_mc_cycles (ex_mc_cycles),
    .mem_stallreq (mem_stallreq),
    .flush_req    (flush_req),
    .ex_mc_stall  (mc_stall),
    .ex_mc_done   (mc_done),
    .ex_busy      (mc_busy)
  );

  // Reset masks every output so the pipe sees a quiet control word while held.
  always_comb begin
    stall = STALL_NONE;
    flush = 1'b0;
    if (rst) begin
      stall = STALL_NONE;
    end else if (flush_req) begin
      flush = 1'b1;
    end else if (mem_stallreq) begin
      stall = STALL_MEM;
    end else if (mc_stall) begin
      stall = STALL_EX;
    end else if (id_stallreq) begin
      stall = STALL_ID;
    end else if (if_stallreq) begin
      stall = STALL_IF;
    end
  end

  assign ex_mc_done = mc_done && !rst;
  assign ex_busy    = mc_busy && !rst;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios then randomized
// traffic, all checked against a cycle-level reference model.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst, if_stallreq, id_stallreq, ex_mc_start, mem_stallreq, flush_req;
  logic [5:0] ex_mc_cycles;
  logic [4:0] stall;
  logic       flush, ex_mc_done, ex_busy;

  pipe_ctrl #(.CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_stallreq  (if_stallreq),
    .id_stallreq  (id_stallreq),
    .ex_mc_start  (ex_mc_start),
    .ex_mc_cycles (ex_mc_cycles),
    .mem_stallreq (mem_stallreq),
    .flush_req    (flush_req),
    .stall        (stall),
    .flush        (flush),
    .ex_mc_done   (ex_mc_done),
    .ex_busy      (ex_busy)
  );

  always #5 clk = ~clk;

  int passes = 0;
  int checks = 0;

  // Reference model: an op in flight and how many cycles it still owes EX
  // (the done cycle counts as the last one).
  bit m_busy = 1'b0;
  int m_left = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive one cycle of inputs, check all outputs mid-cycle, then advance the model.
  task automatic step(input bit r, input bit fi, input bit fd, input bit st,
                      input logic [5:0] cy, input bit m, input bit f);
    bit         mc_stall, exp_done;
    logic [4:0] exp_stall;
    @(negedge clk);
    rst = r; if_stallreq = fi; id_stallreq = fd; ex_mc_start = st;
    ex_mc_cycles = cy; mem_stallreq = m; flush_req = f;
    #1;
    mc_stall = m_busy ? (m_left != 1) : (st && cy != 0);
    exp_done = !r && m_busy && m_left == 1 && !m && !f;
    if (r || f)        exp_stall = 5'b00000;
    else if (m)        exp_stall = 5'b01111;
    else if (mc_stall) exp_stall = 5'b00111;
    else if (fd)       exp_stall = 5'b00011;
    else if (fi)       exp_stall = 5'b00001;
    else               exp_stall = 5'b00000;
    chk("stall", 8'(stall), 8'(exp_stall));
    chk("flush", 8'(flush), 8'(!r && f));
    chk("done",  8'(ex_mc_done), 8'(exp_done));
    chk("busy",  8'(ex_busy), 8'(!r && m_busy));
    if (r || f) begin
      m_busy = 0; m_left = 0;
    end else if (!m_busy) begin
      if (st && cy != 0 && !m) begin m_busy = 1; m_left = int'(cy); end
    end else if (!m) begin
      m_left--;
      if (m_left == 0) m_busy = 0;
    end
  endtask

  initial begin
    rst = 1; if_stallreq = 0; id_stallreq = 0; ex_mc_start = 0;
    ex_mc_cycles = 0; mem_stallreq = 0; flush_req = 0;

    // Reset with every request high: all outputs quiet.
    step(1, 1, 1, 1, 6'd3, 1, 1);
    step(1, 1, 1, 1, 6'd3, 1, 1);
    step(0, 1, 1, 1, 6'd3, 1, 1);
    chk("post_rst_flush", 8'(flush), 8'd1);
    step(0, 0, 0, 0, 6'd0, 0, 0);
    chk("idle_stall", 8'(stall), 8'h00);

    // Load-use bubble for exactly one cycle.
    step(0, 0, 1, 0, 6'd0, 0, 0);
    chk("load_use", 8'(stall), 8'b00011);
    step(0, 0, 0, 0, 6'd0, 0, 0);
    chk("load_use_end", 8'(stall), 8'h00);

    // Single-cycle op: no stall, no state change.
    step(0, 0, 0, 1, 6'd0, 0, 0);
    chk("mc_zero", 8'(stall), 8'h00);

    // Divide N=3: t..t+2 stall, done at t+3.
    step(0, 0, 0, 1, 6'd3, 0, 0);
    chk("div_t0", 8'(stall), 8'b00111);
    step(0, 0, 0, 1, 6'd3, 0, 0);
    step(0, 0, 0, 1, 6'd3, 0, 0);
    chk("div_t2", 8'(stall), 8'b00111);
    step(0, 0, 0, 0, 6'd0, 0, 0);
    chk("div_done", 8'(ex_mc_done), 8'd1);
    step(0, 0, 0, 0, 6'd0, 0, 0);
    chk("div_idle", 8'(ex_busy), 8'd0);

    // Divide N=3 with MEM wait at t+1..t+2: done slips to t+5.
    step(0, 0, 0, 1, 6'd3, 0, 0);
    step(0, 0, 0, 1, 6'd3, 1, 0);
    chk("mem_wait", 8'(stall), 8'b01111);
    step(0, 0, 0, 1, 6'd3, 1, 0);
    step(0, 0, 0, 1, 6'd3, 0, 0);
    step(0, 0, 0, 1, 6'd3, 0, 0);
    chk("mem_wait_nodone", 8'(ex_mc_done), 8'd0);
    step(0, 0, 0, 0, 6'd0, 0, 0);
    chk("mem_wait_done", 8'(ex_mc_done), 8'd1);

    // Flush mid-divide N=5.
    step(0, 0, 0, 1, 6'd5, 0, 0);
    step(0, 0, 0, 1, 6'd5, 0, 0);
    step(0, 0, 0, 1, 6'd5, 0, 1);
    chk("flush_mid", 8'(flush), 8'd1);
    step(0, 0, 0, 0, 6'd0, 0, 0);
    chk("flush_busy", 8'(ex_busy), 8'd0);

    // Priority overlap.
    step(0, 1, 1, 0, 6'd0, 0, 0);
    chk("if_id", 8'(stall), 8'b00011);
    step(0, 1, 1, 0, 6'd0, 1, 0);
    chk("if_id_mem", 8'(stall), 8'b01111);

    // Randomized traffic; EX holds start until the predicted done cycle.
    for (int n = 0; n < 600; n++) begin
      bit r, f, m, fi, fd, st;
      logic [5:0] cy;
      r  = ($urandom_range(63) == 0);
      f  = ($urandom_range(15) == 0);
      m  = ($urandom_range(4) == 0);
      fi = ($urandom_range(4) == 0);
      fd = ($urandom_range(4) == 0);
      if (m_busy) begin
        st = !(m_left == 1 && !m && !f && !r);
        cy = 6'($urandom_range(7));
      end else begin
        st = ($urandom_range(2) == 0);
        cy = 6'($urandom_range(7));
      end
      step(r, fi, fd, st, cy, m, f);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
